display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
Sequences the multiplexed 6-digit seven-segment display that shows the signed Booth product. It generates the per-digit refresh timing internally and walks the digit index through every position. It double-buffers the incoming BCD value so a frame never mixes old and new data. It also applies leading-zero blanking and places the minus sign, then drives registered active-low anode and segment lines.

Parameters:
NUM_DIGITS, 6, number of display positions; index 0 is the rightmost digit.
REFRESH_DIV, 100000, clk cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
load  input  1  single-cycle strobe; capture value_bcd/negative into the pending buffer
value_bcd  input  4*NUM_DIGITS  magnitude in BCD; nibble i = digit i
negative  input  1  sign of the value to load
pending  output  1  high from load until the value is applied at a frame start
frame_start  output  1  one-cycle pulse when digit index wraps to 0 and a new frame begins
sign_ovf  output  1  negative value with no free position left for the '-'
an  output  NUM_DIGITS  anode enables, active-low, one-hot-low while active
seg  output  7  segments gfedcba, active-low

Behaviour:
- Reset values: an all 1; seg 7'h7F; pending 0; frame_start 0; sign_ovf 0; slot counter 0; digit index 0; displayed buffer 0 (positive); pending buffer 0.
- Slot counter counts 0..REFRESH_DIV-1, then wraps. On wrap, digit index increments; index NUM_DIGITS-1 wraps to 0.
- On the cycle the index wraps to 0: frame_start pulses. If pending=1, the pending buffer copies into the displayed buffer and pending clears that same cycle.
- Blank phase (slot counter < BLANK_CYCLES): an all 1, seg 7'h7F. Active phase: an[idx]=0, all other bits 1.
- an and seg are registered: one cycle of latency from counter state to pins.
- load while pending=1 overwrites the pending buffer; latest value wins, pending stays 1.
- load on the same cycle as a frame-start transfer: the old pending value is applied, the new value is captured, and pending stays 1.
- Leading-zero blanking: let k = index of the most significant nonzero nibble, with k=0 if all nibbles are zero. Digits above k are blank. Digit 0 always shows its value.
- Sign: if negative and the magnitude is nonzero and k<NUM_DIGITS-1, digit k+1 shows '-' (7'b0111111).
- If negative and k=NUM_DIGITS-1, no '-' is shown and sign_ovf=1.
- Negative zero displays '0' with no sign and sign_ovf=0.
- sign_ovf is derived from the displayed buffer, so it updates at frame start.
- Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any nibble above 9 shows 'E' (0000110).
- Reset mid-frame: the next cycle is in full reset state; the display stays dark for BLANK_CYCLES+1 cycles, then digit 0 shows '0'.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: leading-zero blanking and floating sign exactly as described above.
- Undefined: all digits show their nibble, including zeros.
  - When negative and nonzero, digit NUM_DIGITS-1 is forced to '-'.
  - sign_ovf=1 if that nibble is nonzero; the nibble is hidden either way.

Test Plan:
(Bench uses REFRESH_DIV=8, BLANK_CYCLES=2, macro defined unless stated.)
- Reset, no load -> an=6'b111111 for 3 cycles, then an=6'b111110 with seg=1000000. Digits 1-5 are blank across a full 48-cycle frame; frame_start pulses every 48 cycles.
- load value_bcd=0x001234, negative=1 mid-frame -> pending=1 until the next frame_start, then 0.
  - Next frame shows digits 0-3 as 4,3,2,1 and digit 4 as '-' (0111111); digit 5 is blank; sign_ovf=0.
- load 0x032768 with negative=1, then load 0x000005 with negative=0 before the frame boundary -> only '5' is ever displayed; no '-' appears.
- load 0x999999 with negative=1 -> all digits show '9' and sign_ovf=1. load 0x000000 with negative=1 -> single '0', sign_ovf=0.
- load 0x00A000 -> digit 3 shows 'E' (0000110), digits 0-2 show '0'.
- Assert reset for 1 cycle during the digit-3 active phase -> outputs reset next cycle, pending=0, the display returns to '0'.
- Macro undefined: load 0x001234 with negative=1 -> digits 4 shows 0 and digit 5 shows '-', sign_ovf=0.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - load/display bundle for the scan controller
// Purpose: groups the value-load handshake and the display pin outputs of
//          display_scan_controller so they travel as one port.
// Signals:
//   load        single-cycle strobe capturing value_bcd/negative
//   value_bcd   4*NUM_DIGITS BCD magnitude, nibble i = digit i (0 = rightmost)
//   negative    sign of the value being loaded
//   pending     a loaded value is waiting for the next frame start
//   frame_start one-cycle pulse at the start of each frame
//   sign_ovf    negative value with no free position for the '-'
//   an          active-low anode enables
//   seg         active-low segments, gfedcba
// Modports: master drives the load side, slave is the controller.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_bcd;
    logic                    negative;
    logic                    pending;
    logic                    frame_start;
    logic                    sign_ovf;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;

    modport master (
        output load, value_bcd, negative,
        input  pending, frame_start, sign_ovf, an, seg
    );

    modport slave (
        input  load, value_bcd, negative,
        output pending, frame_start, sign_ovf, an, seg
    );
endinterface

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed seven-segment scan controller
// Purpose: time-multiplexes a NUM_DIGITS seven-segment display. Each digit gets
//          a REFRESH_DIV-cycle slot whose first BLANK_CYCLES are dark. A loaded
//          value is held in a pending buffer and moved to the displayed buffer
//          only at a frame start, so one frame never mixes two values.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    display_scan_controller_if.slave (load/value_bcd/negative in;
//          pending/frame_start/sign_ovf/an/seg out)
// Build option: LEADING_ZERO_BLANK_EN - when defined, leading zeros are blanked
//          and the '-' floats to just left of the most significant digit; when
//          undefined, every digit shows its nibble and the top digit carries '-'.
module display_scan_controller #(
    parameter int NUM_DIGITS   = 6,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    display_scan_controller_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [CW-1:0]         slot_cnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         disp_val;
    logic                  disp_neg;
    logic [VW-1:0]         pend_val;
    logic                  pend_neg;
    logic                  pending_q;
    logic                  frame_start_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;

    logic                  slot_wrap;
    logic                  frame_wrap;
    logic [3:0]            cur_nib;
    logic                  mag_nz;
    logic [6:0]            seg_active;
    logic                  sign_ovf_c;
    logic                  blank_phase;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b0000110;
        endcase
    endfunction

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);
    assign cur_nib    = disp_val[{idx, 2'b00} +: 4];
    assign mag_nz     = |disp_val;

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;
    logic          sign_here;

    // Most significant nonzero nibble; stays 0 for an all-zero value so digit 0 still shows.
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val[4*i +: 4] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    assign sign_here  = disp_neg && mag_nz &&
                        ({1'b0, idx} == ({1'b0, msd} + (IW+1)'(1)));
    assign seg_active = (idx <= msd) ? seg_encode(cur_nib) :
                        sign_here    ? SEG_MINUS : SEG_OFF;
    assign sign_ovf_c = disp_neg && mag_nz && (msd == IDX_LAST);
`else
    logic [3:0] top_nib;
    logic       show_sign;

    // The top position is given over to the sign, hiding whatever nibble sits there.
    assign top_nib    = disp_val[VW-1 -: 4];
    assign show_sign  = disp_neg && mag_nz;
    assign seg_active = (show_sign && (idx == IDX_LAST)) ? SEG_MINUS : seg_encode(cur_nib);
    assign sign_ovf_c = show_sign && (top_nib != 4'd0);
`endif

    assign blank_phase = (slot_cnt < BLANK_END);
    assign an_next     = blank_phase ? '1 : ~(NUM_DIGITS'(1) << idx);
    assign seg_next    = blank_phase ? SEG_OFF : seg_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt      <= '0;
            idx           <= '0;
            disp_val      <= '0;
            disp_neg      <= 1'b0;
            pend_val      <= '0;
            pend_neg      <= 1'b0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + CW'(1);
            if (slot_wrap) begin
                idx <= frame_wrap ? '0 : idx + IW'(1);
            end
            frame_start_q <= frame_wrap;

            // The transfer reads the old pending buffer, so a load on this same
            // edge is captured for the following frame and keeps pending set.
            if (frame_wrap && pending_q) begin
                disp_val <= pend_val;
                disp_neg <= pend_neg;
            end
            if (bus.load) begin
                pend_val  <= bus.value_bcd;
                pend_neg  <= bus.negative;
                pending_q <= 1'b1;
            end else if (frame_wrap) begin
                pending_q <= 1'b0;
            end

            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.frame_start = frame_start_q;
    assign bus.sign_ovf    = sign_ovf_c;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] BL = 7'h7F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_controller_if #(.NUM_DIGITS(6)) bus ();

    display_scan_controller #(
        .NUM_DIGITS  (6),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int fails  = 0;
    int n;
    logic [6:0] exp_seg [6];

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [6:0] d0, d1, d2, d3, d4, d5);
        exp_seg[0] = d0; exp_seg[1] = d1; exp_seg[2] = d2;
        exp_seg[3] = d3; exp_seg[4] = d4; exp_seg[5] = d5;
    endtask

    // Returns the number of negedges until frame_start is seen (frame edge E).
    task automatic wait_frame(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 200 && cnt < 0; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) cnt = i;
        end
        if (cnt < 0) chk({31'd0, bus.frame_start}, 32'd1, "frame_timeout");
    endtask

    // Called at the negedge after frame edge E; samples each digit mid active
    // phase (E+8d+5) and returns at the negedge after E+45.
    task automatic check_digits(input string tag);
        logic [5:0] ea;
        @(negedge clk);
        chk({26'd0, bus.an}, 32'h3F, {tag, "_blank"});
        for (int d = 0; d < 6; d++) begin
            repeat ((d == 0) ? 4 : 8) @(negedge clk);
            ea = ~(6'b000001 << d);
            chk({26'd0, bus.an}, {26'd0, ea}, $sformatf("%s_an%0d", tag, d));
            chk({25'd0, bus.seg}, {25'd0, exp_seg[d]}, $sformatf("%s_seg%0d", tag, d));
        end
    endtask

    task automatic load_val(input logic [23:0] v, input logic neg);
        bus.value_bcd = v;
        bus.negative  = neg;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;
        bus.value_bcd = '0;
        bus.negative = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk({26'd0, bus.an}, 32'h3F, "rst_an");
        chk({25'd0, bus.seg}, 32'h7F, "rst_seg");
        chk({31'd0, bus.pending}, 32'd0, "rst_pending");
        chk({31'd0, bus.frame_start}, 32'd0, "rst_frame_start");
        chk({31'd0, bus.sign_ovf}, 32'd0, "rst_sign_ovf");
        repeat (2) @(negedge clk);
        chk({26'd0, bus.an}, 32'h3F, "startup_dark");
        @(negedge clk);
        chk({26'd0, bus.an}, 32'h3E, "startup_an0");
        chk({25'd0, bus.seg}, {25'd0, S0}, "startup_seg0");

        wait_frame(n);
        chk(n, 45, "first_frame_latency");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S0, BL, BL, BL, BL, BL);
`else
        set_exp(S0, S0, S0, S0, S0, S0);
`endif
        check_digits("zero");
        wait_frame(n);
        chk(n, 3, "frame_period");

        repeat (10) @(negedge clk);
        load_val(24'h001234, 1'b1);
        chk({31'd0, bus.pending}, 32'd1, "neg1234_pending_set");
        wait_frame(n);
        chk({31'd0, bus.pending}, 32'd0, "neg1234_pending_clr");
        chk({31'd0, bus.sign_ovf}, 32'd0, "neg1234_ovf");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S4, S3, S2, S1, MN, BL);
`else
        set_exp(S4, S3, S2, S1, S0, MN);
`endif
        check_digits("neg1234");

        load_val(24'h032768, 1'b1);
        load_val(24'h000005, 1'b0);
        chk({31'd0, bus.pending}, 32'd1, "overwrite_pending");
        wait_frame(n);
        chk({31'd0, bus.pending}, 32'd0, "overwrite_pending_clr");
        chk({31'd0, bus.sign_ovf}, 32'd0, "overwrite_ovf");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S5, BL, BL, BL, BL, BL);
`else
        set_exp(S5, S0, S0, S0, S0, S0);
`endif
        check_digits("overwrite");

        load_val(24'h999999, 1'b1);
        chk({31'd0, bus.sign_ovf}, 32'd0, "ovf_before_frame");
        wait_frame(n);
        chk({31'd0, bus.sign_ovf}, 32'd1, "ovf_after_frame");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S9, S9, S9, S9, S9, S9);
`else
        set_exp(S9, S9, S9, S9, S9, MN);
`endif
        check_digits("neg999999");

        load_val(24'h000000, 1'b1);
        wait_frame(n);
        chk({31'd0, bus.sign_ovf}, 32'd0, "negzero_ovf");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S0, BL, BL, BL, BL, BL);
`else
        set_exp(S0, S0, S0, S0, S0, S0);
`endif
        check_digits("negzero");

        load_val(24'h00A000, 1'b0);
        wait_frame(n);
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S0, S0, S0, SE, BL, BL);
`else
        set_exp(S0, S0, S0, SE, S0, S0);
`endif
        check_digits("nibbleA");

        wait_frame(n);
        load_val(24'h000007, 1'b0);
        repeat (46) @(negedge clk);
        load_val(24'h000003, 1'b0);
        chk({31'd0, bus.frame_start}, 32'd1, "collide_frame_start");
        chk({31'd0, bus.pending}, 32'd1, "collide_pending");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S7, BL, BL, BL, BL, BL);
`else
        set_exp(S7, S0, S0, S0, S0, S0);
`endif
        check_digits("collide_old");
        wait_frame(n);
        chk({31'd0, bus.pending}, 32'd0, "collide_pending_clr");
`ifdef LEADING_ZERO_BLANK_EN
        set_exp(S3, BL, BL, BL, BL, BL);
`else
        set_exp(S3, S0, S0, S0, S0, S0);
`endif
        check_digits("collide_new");

        wait_frame(n);
        load_val(24'h000042, 1'b0);
        repeat (28) @(negedge clk);
        chk({26'd0, bus.an}, 32'h37, "midreset_digit3");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk({26'd0, bus.an}, 32'h3F, "midreset_an");
        chk({25'd0, bus.seg}, 32'h7F, "midreset_seg");
        chk({31'd0, bus.pending}, 32'd0, "midreset_pending");
        chk({31'd0, bus.frame_start}, 32'd0, "midreset_frame_start");
        chk({31'd0, bus.sign_ovf}, 32'd0, "midreset_sign_ovf");
        repeat (2) @(negedge clk);
        chk({26'd0, bus.an}, 32'h3F, "midreset_dark");
        @(negedge clk);
        chk({26'd0, bus.an}, 32'h3E, "midreset_an0");
        chk({25'd0, bus.seg}, {25'd0, S0}, "midreset_seg0");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
